conv_encoder: RTL

Rate-1/2, constraint-length-3 convolutional encoder: the transmit-side counterpart of the Viterbi decoder's ACS/traceback path. It accepts one information bit per handshake and emits one 2-bit code symbol per bit. It terminates every frame with K-1 = 2 zero tail bits so the decoder's trellis ends in state 2'b00. Its symbol and state encoding is the one the ACS units consume as `data_recv` and `self_state`.

---
 rtl/viterbi_pkg.sv | 26 ++
 rtl/conv_branch_fn.sv | 26 ++
 rtl/conv_encoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
//==[ viterbi_pkg ]== shared trellis constants, generators and encoder FSM states
//==[ rev 1.0 ]==================================================================
`default_nettype none

package viterbi_pkg;

  localparam int K     = 3;
  localparam int SYM_W = 2;
  localparam int ST_W  = K - 1;

  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b101;

  typedef enum logic [1:0] {
    ENC_DATA  = 2'd0,
    ENC_TAIL1 = 2'd1,
    ENC_TAIL2 = 2'd2
  } enc_state_e;

  function automatic logic gen_parity(input logic [K-1:0] taps, input logic [K-1:0] gen);
    return ^(taps & gen);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_branch_fn.sv
//==[ conv_branch_fn ]== one trellis branch: (bit, state) -> (symbol, next state)
//==[ rev 1.0 ]==================================================================
`default_nettype none

module conv_branch_fn
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic             b,
  input  logic [ST_W-1:0]  state,
  output logic [SYM_W-1:0] sym,
  output logic [ST_W-1:0]  next_state
);

  logic [K-1:0] taps;

  // Tap vector is {newest bit, b(t-1), b(t-2)}; symbol is {c0, c1}.
  assign taps       = {b, state};
  assign sym        = {gen_parity(taps, G0), gen_parity(taps, G1)};
  assign next_state = {b, state[ST_W-1]};

endmodule

`default_nettype wire

// File: rtl/conv_encoder.sv
//==[ conv_encoder ]== rate-1/2 K=3 convolutional encoder, zero-tail terminated frames
//==[ rev 1.0 ]=====================================================================
`default_nettype none

module conv_encoder
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0      = G0_DEF,
  parameter logic [K-1:0] G1      = G1_DEF,
  parameter int           MAX_LEN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic [ST_W-1:0]  out_state,
  output logic             out_tail,
  output logic             out_last,
  output logic             frame_err
);

  localparam int               CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

  enc_state_e       state;
  enc_state_e       state_nx;
  logic [ST_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;

  logic             out_free;
  logic             accept;
  logic             load;
  logic             enc_bit;
  logic             tail_sym;
  logic             last_sym;
  logic             cnt_hit;
  logic             force_end;
  logic [SYM_W-1:0] sym_nx;
  logic [ST_W-1:0]  sr_nx;

  assign out_free  = !out_valid || out_ready;
  assign cnt_hit   = (cnt == CNT_MAX - 1'b1);
  assign force_end = accept && cnt_hit && !in_last;

  conv_branch_fn #(
    .G0 (G0),
    .G1 (G1)
  ) u_branch (
    .b          (enc_bit),
    .state      (sr),
    .sym        (sym_nx),
    .next_state (sr_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENC_DATA;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ENC_DATA:  if (accept && (in_last || cnt_hit)) state_nx = ENC_TAIL1;
      ENC_TAIL1: if (out_free) state_nx = ENC_TAIL2;
      ENC_TAIL2: if (out_free) state_nx = ENC_DATA;
      default:   state_nx = ENC_DATA;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    accept   = 1'b0;
    load     = 1'b0;
    enc_bit  = 1'b0;
    tail_sym = 1'b0;
    last_sym = 1'b0;
    unique case (state)
      ENC_DATA: begin
        in_ready = out_free;
        accept   = in_valid && out_free;
        load     = in_valid && out_free;
        enc_bit  = in_bit;
      end
      ENC_TAIL1: begin
        load     = out_free;
        tail_sym = 1'b1;
      end
      ENC_TAIL2: begin
        load     = out_free;
        tail_sym = 1'b1;
        last_sym = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Output register reloads in the cycle it is consumed, so a held-high
  // out_ready sees one symbol per clock with no bubbles between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_state <= '0;
      out_tail  <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
      sr        <= '0;
      cnt       <= '0;
    end else begin
      frame_err <= force_end;
      if (load) begin
        out_valid <= 1'b1;
        out_sym   <= sym_nx;
        out_state <= sr;
        out_tail  <= tail_sym;
        out_last  <= last_sym;
        sr        <= sr_nx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        cnt <= cnt + 1'b1;
      end else if (load && last_sym) begin
        cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire
